// File: rtl/block_data_memory_if.sv
// Request/response bundle between the data cache controller and the line memory.
// The controller is the master: it raises a level enable with address/data/mask
// and stalls while BUSYWAIT is high.
interface block_data_memory_if #(
  parameter int ADDR_WIDTH = 28,
  parameter int LINE_BYTES = 16
);
  logic                    READ_EN;
  logic                    WRITE_EN;
  logic [ADDR_WIDTH-1:0]   ADDRESS;
  logic [LINE_BYTES*8-1:0] WRITE_DATA;
  logic [LINE_BYTES-1:0]   WRITE_MASK;
  logic [LINE_BYTES*8-1:0] READ_DATA;
  logic                    BUSYWAIT;
  logic                    ERROR;

  modport master (
    output READ_EN, WRITE_EN, ADDRESS, WRITE_DATA, WRITE_MASK,
    input  READ_DATA, BUSYWAIT, ERROR
  );

  modport slave (
    input  READ_EN, WRITE_EN, ADDRESS, WRITE_DATA, WRITE_MASK,
    output READ_DATA, BUSYWAIT, ERROR
  );
endinterface

// File: rtl/block_data_memory.sv
// Line-transfer main memory behind the data cache. A request seen in IDLE is
// latched, then moved BEAT_BYTES per cycle in XFER, followed by one DONE cycle
// that lets the requester drop its enable before the FSM samples again.
module block_data_memory #(
  parameter int ADDR_WIDTH  = 28,
  parameter int LINE_BYTES  = 16,
  parameter int BEAT_BYTES  = 1,
  parameter int DEPTH_LINES = 64
) (
  input logic               CLK,
  input logic               RESET,
  block_data_memory_if.slave bus
);

  localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IDX_W  = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [BEAT_W-1:0]       beat;
  logic [BEAT_W-1:0]       beat_next;

  logic                    op_write;
  logic [IDX_W-1:0]        line_idx;
  logic [LINE_BYTES*8-1:0] wdata;
  logic [LINE_BYTES-1:0]   wmask;

  logic [LINE_BYTES*8-1:0] read_data;
  logic                    error;

  // Storage is deliberately never reset: RESET only aborts the transfer.
  logic [7:0]              mem [DEPTH_LINES][LINE_BYTES];

  logic                    one_req;
  logic                    both_req;
  logic                    unused_addr;

  assign one_req  = bus.READ_EN ^ bus.WRITE_EN;
  assign both_req = bus.READ_EN & bus.WRITE_EN;

  // Upper address bits are ignored so addresses wrap onto the implemented lines.
  assign unused_addr = ^bus.ADDRESS;

  assign bus.READ_DATA = read_data;
  assign bus.ERROR     = error;
  assign bus.BUSYWAIT  = !RESET & ((state == XFER) | ((state == IDLE) & one_req));

  // Next-state and beat-counter logic; inputs are only looked at in IDLE.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    case (state)
      IDLE: begin
        if (one_req) begin
          state_next = XFER;
          beat_next  = {BEAT_W{1'b0}};
        end else begin
          state_next = IDLE;
        end
      end
      XFER: begin
        if (beat == LAST_BEAT) begin
          state_next = DONE;
          beat_next  = {BEAT_W{1'b0}};
        end else begin
          beat_next  = beat + {{(BEAT_W-1){1'b0}}, 1'b1};
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        beat_next  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= IDLE;
      beat  <= {BEAT_W{1'b0}};
    end else begin
      state <= state_next;
      beat  <= beat_next;
    end
  end

  // Capture the request in IDLE so bus changes during XFER have no effect.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      op_write <= 1'b0;
      line_idx <= {IDX_W{1'b0}};
      wdata    <= {(LINE_BYTES*8){1'b0}};
      wmask    <= {LINE_BYTES{1'b0}};
    end else if ((state == IDLE) && one_req) begin
      op_write <= bus.WRITE_EN;
      line_idx <= bus.ADDRESS[IDX_W-1:0];
      wdata    <= bus.WRITE_DATA;
      wmask    <= bus.WRITE_MASK;
    end
  end

  // Read beats copy the current beat's bytes into their lanes; other lanes hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      read_data <= {(LINE_BYTES*8){1'b0}};
    end else if ((state == XFER) && !op_write) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        if (BEAT_W'(k / BEAT_BYTES) == beat) begin
          read_data[8*k +: 8] <= mem[line_idx][k];
        end
      end
    end
  end

  // Flag a simultaneous read+write request seen in IDLE for exactly one cycle.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      error <= 1'b0;
    end else begin
      error <= (state == IDLE) & both_req;
    end
  end

  // Write beats commit masked bytes; a beat sampled together with RESET is dropped.
  always_ff @(posedge CLK) begin
    if (!RESET && (state == XFER) && op_write) begin
      for (int k = 0; k < LINE_BYTES; k++) begin
        if ((BEAT_W'(k / BEAT_BYTES) == beat) && wmask[k]) begin
          mem[line_idx][k] <= wdata[8*k +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_block_data_memory.sv
// Directed bench for block_data_memory: a 1-byte-beat instance (A) and a
// 4-byte-beat instance (B) sharing clock and reset.
module tb_block_data_memory;

  logic clk;
  logic rst;

  int total;
  int passed;

  block_data_memory_if #(.ADDR_WIDTH(28), .LINE_BYTES(16)) ia ();
  block_data_memory_if #(.ADDR_WIDTH(28), .LINE_BYTES(16)) ib ();

  block_data_memory #(
    .ADDR_WIDTH(28), .LINE_BYTES(16), .BEAT_BYTES(1), .DEPTH_LINES(64)
  ) dut_a (
    .CLK(clk), .RESET(rst), .bus(ia)
  );

  block_data_memory #(
    .ADDR_WIDTH(28), .LINE_BYTES(16), .BEAT_BYTES(4), .DEPTH_LINES(64)
  ) dut_b (
    .CLK(clk), .RESET(rst), .bus(ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic sel, input logic re, input logic we,
                       input logic [27:0] addr, input logic [127:0] data,
                       input logic [15:0] mask);
    if (sel) begin
      ib.READ_EN = re; ib.WRITE_EN = we; ib.ADDRESS = addr;
      ib.WRITE_DATA = data; ib.WRITE_MASK = mask;
    end else begin
      ia.READ_EN = re; ia.WRITE_EN = we; ia.ADDRESS = addr;
      ia.WRITE_DATA = data; ia.WRITE_MASK = mask;
    end
  endtask

  // One access started just after an edge in IDLE; returns busy-cycle count
  // and READ_DATA seen in the DONE cycle, then idles one cycle.
  task automatic access(input logic sel, input logic wr, input logic [27:0] addr,
                        input logic [127:0] data, input logic [15:0] mask,
                        output int busy, output logic [127:0] rdata);
    logic bw;
    drive(sel, !wr, wr, addr, data, mask);
    busy = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      bw = sel ? ib.BUSYWAIT : ia.BUSYWAIT;
      if (bw) begin
        busy++;
        @(posedge clk);
        #1;
      end else begin
        break;
      end
    end
    rdata = sel ? ib.READ_DATA : ia.READ_DATA;
    drive(sel, 1'b0, 1'b0, addr, data, mask);
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] D0     = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] AA     = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAAA;
  localparam logic [127:0] D0_MSK = 128'h0F0E0D0C0B0A0908AAAAAAAA03020100;
  localparam logic [127:0] DB     = 128'hDEADBEEF0123456789ABCDEFCAFEF00D;
  localparam logic [127:0] DW     = 128'h55443322110099887766554433221100;
  localparam logic [127:0] OLD    = 128'h11111111111111111111111111111111;
  localparam logic [127:0] NEW    = 128'hCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCCC;
  localparam logic [127:0] PART   = 128'h11111111111111111111CCCCCCCCCCCC;

  initial begin
    int busy;
    logic [127:0] rd;
    total  = 0;
    passed = 0;
    rst    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 28'h0, 128'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 28'h0, 128'h0, 16'h0);

    // Reset state; a request during reset must not raise BUSYWAIT.
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 1'b1, 1'b0, 28'h0, 128'h0, 16'h0);
    drive(1'b1, 1'b1, 1'b0, 28'h0, 128'h0, 16'h0);
    #1;
    check("rst_busy_a", {127'h0, ia.BUSYWAIT}, 128'h0);
    check("rst_busy_b", {127'h0, ib.BUSYWAIT}, 128'h0);
    check("rst_rdata_a", ia.READ_DATA, 128'h0);
    check("rst_rdata_b", ib.READ_DATA, 128'h0);
    check("rst_err_a", {127'h0, ia.ERROR}, 128'h0);
    check("rst_err_b", {127'h0, ib.ERROR}, 128'h0);
    drive(1'b0, 1'b0, 1'b0, 28'h0, 128'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 28'h0, 128'h0, 16'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full-mask write then read of line 5, 17 busy cycles each.
    access(1'b0, 1'b1, 28'h5, D0, 16'hFFFF, busy, rd);
    check("wr_busy_a", 128'(busy), 128'd17);
    access(1'b0, 1'b0, 28'h5, 128'h0, 16'h0, busy, rd);
    check("rd_busy_a", 128'(busy), 128'd17);
    check("rd_data_a", rd, D0);

    // Masked write touches only bytes 4..7; READ_DATA holds across the write.
    access(1'b0, 1'b1, 28'h5, AA, 16'h00F0, busy, rd);
    check("mwr_busy", 128'(busy), 128'd17);
    check("mwr_hold", rd, D0);
    access(1'b0, 1'b0, 28'h5, 128'h0, 16'h0, busy, rd);
    check("mrd_data", rd, D0_MSK);

    // 4-byte beats: 5 busy cycles per access.
    access(1'b1, 1'b1, 28'h3, DB, 16'hFFFF, busy, rd);
    check("wr_busy_b", 128'(busy), 128'd5);
    access(1'b1, 1'b0, 28'h3, 128'h0, 16'h0, busy, rd);
    check("rd_busy_b", 128'(busy), 128'd5);
    check("rd_data_b", rd, DB);

    // Both enables for three cycles: ERROR three cycles, no access.
    drive(1'b0, 1'b1, 1'b1, 28'h5, NEW, 16'hFFFF);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("both_busy", {127'h0, ia.BUSYWAIT}, 128'h0);
      @(posedge clk);
      #1;
      check("both_err", {127'h0, ia.ERROR}, 128'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 28'h5, NEW, 16'hFFFF);
    #1;
    check("both_busy_end", {127'h0, ia.BUSYWAIT}, 128'h0);
    @(posedge clk);
    #1;
    check("both_err_clr", {127'h0, ia.ERROR}, 128'h0);
    check("both_rdata", ia.READ_DATA, D0_MSK);
    access(1'b0, 1'b0, 28'h5, 128'h0, 16'h0, busy, rd);
    check("both_store", rd, D0_MSK);

    // Address wrap: 0x45 and 0x05 are the same line.
    access(1'b0, 1'b1, 28'h45, DW, 16'hFFFF, busy, rd);
    access(1'b0, 1'b0, 28'h05, 128'h0, 16'h0, busy, rd);
    check("wrap_data", rd, DW);

    // Reset at write beat 6 keeps beats 0..5 only.
    access(1'b0, 1'b1, 28'h7, OLD, 16'hFFFF, busy, rd);
    access(1'b0, 1'b0, 28'h7, 128'h0, 16'h0, busy, rd);
    check("old_data", rd, OLD);
    drive(1'b0, 1'b0, 1'b1, 28'h7, NEW, 16'hFFFF);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 28'h7, NEW, 16'hFFFF);
    #1;
    check("abort_busy_rst", {127'h0, ia.BUSYWAIT}, 128'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", {127'h0, ia.BUSYWAIT}, 128'h0);
    check("abort_rdata", ia.READ_DATA, 128'h0);
    access(1'b0, 1'b0, 28'h7, 128'h0, 16'h0, busy, rd);
    check("abort_rd_busy", 128'(busy), 128'd17);
    check("abort_data", rd, PART);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
